lc3_panel_io: RTL
=================

Name: lc3_panel_io

Overview:
Board front-panel I/O block for the LC-3 FPGA top level. It replaces raw pushbutton-as-clock wiring with synchronised, debounced keys that produce one-cycle step pulses in the system clock domain. It also drives a parametrised bank of active-low seven-segment digits from a load-captured value, with per-digit blanking.
It sits between the board pins (KEY, HEX) and the LC3 core's step/clock-enable and register-view outputs.

Parameters:
NUM_KEYS, 2, number of active-low pushbuttons handled.
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples required to accept a key change; minimum 2.
NUM_DIGITS, 6, number of seven-segment digits driven.
REPEAT_CYCLES, 25000000, auto-repeat period; used only with LC3_PANEL_REPEAT_EN.

Ports:
clk  input  1  system clock; single clock domain.
reset_n  input  1  asynchronous, active-low reset.
key_n  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk.
key_level  output  NUM_KEYS  debounced key state, active-low (1 = released).
key_pulse  output  NUM_KEYS  one-cycle active-high pulse per accepted press.
disp_value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i.
disp_load  input  1  capture disp_value into the shadow register.
disp_blank  input  NUM_DIGITS  1 = digit i dark.
hex  output  7*NUM_DIGITS  active-low segments; digit i occupies bits [7i+6:7i], bit order g..a.

Behaviour:
- Reset (async assert, sync release):
  - both synchroniser flops = 1; debounce counters = 0; key_level = all 1; key_pulse = 0.
  - shadow register = 0; hex = all 7'h7F.
- Per key:
  - 2-flop synchroniser feeds a counter of width $clog2(DEBOUNCE_CYCLES).
  - Synced sample != key_level: counter increments.
  - Synced sample == key_level: counter clears to 0.
  - On the DEBOUNCE_CYCLES-th consecutive disagreeing sample: key_level takes the sample and the counter clears.
- Latency: key_n low before edge 0 -> key_level falls after edge DEBOUNCE_CYCLES+2 -> key_pulse high after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
- Pulse generation:
  - Pulse only on a key_level 1->0 transition; a release never pulses.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count, giving no level change and no pulse.
- Keys are fully independent; simultaneous presses pulse in the same cycle.
- Display:
  - disp_load high at edge N: shadow captures disp_value at edge N; hex reflects it after edge N+1.
  - disp_load low: shadow holds.
  - hex is registered, decoding shadow and disp_blank every cycle. disp_blank is applied with one cycle of latency and needs no load.
- Segment codes, 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex); blank = 7F.
- Reset asserted mid-debounce or mid-pulse: pulse drops immediately, counters clear, and no pulse is generated at release even if the key is still held. The held key is re-accepted as a new press after DEBOUNCE_CYCLES+3 edges.

Optional Feature:
LC3_PANEL_REPEAT_EN.
- Defined: a per-key repeat counter runs while key_level = 0. After REPEAT_CYCLES cycles held, key_pulse fires again, and once every REPEAT_CYCLES thereafter until release. The counter clears on release and on reset.
- Undefined: the repeat counter is absent; exactly one pulse per press. REPEAT_CYCLES is ignored.

Decomposition:
- Package lc3_panel_pkg:
  - SEG_BLANK (7'h7F);
  - the 16-entry hex-to-segment constant table;
  - a seg_decode function taking 4 bits and returning 7 bits.
- One sub-module, lc3_key_debounce: synchroniser, debounce counter, edge pulse and optional repeat for a single key. It is instantiated NUM_KEYS times in a generate loop.
- Display logic stays in the top module.

Test Plan:
1. Reset values, with DEBOUNCE_CYCLES=4, NUM_DIGITS=6: hold reset_n low -> key_level=2'b11, key_pulse=0, hex all 7'h7F. Release -> after the first edge, every digit = 7'h40.
2. Clean press: key_n[0] low before edge 0 and held -> key_level[0]=0 after edge 6; key_pulse[0]=1 only in the cycle after edge 7. Release -> key_level[0]=1 after 6 edges, no pulse.
3. Bounce: key_n[1] low 3 cycles, high 1, low 3, then high -> key_level[1] stays 1, key_pulse[1] never asserts.
4. Simultaneous: both keys low at the same edge -> key_pulse=2'b11 for one cycle. Reset mid-count (after edge 4) -> no pulse at that time; re-accepted 7 edges after release of reset_n.
5. Display load: disp_value=24'h12AB0F, disp_load pulsed 1 cycle -> digits 0..5 = 0E,40,03,08,24,79. disp_value then changed without a load -> hex unchanged. disp_blank=6'b110000 -> digits 4,5 = 7F one cycle later.
6. Auto-repeat, with LC3_PANEL_REPEAT_EN and REPEAT_CYCLES=10: key0 held 40 cycles past acceptance -> pulses at acceptance, +10, +20, +30, +40. Release -> no further pulses.

Source files
------------

// File: rtl/lc3_panel_pkg.sv
// Shared constants for the LC-3 front-panel block: the seven-segment code table
// (active-low, bit order g..a) and its decoder.
package lc3_panel_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the segment pattern for hex digit n; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/lc3_key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter, press pulse and,
// with LC3_PANEL_REPEAT_EN defined, hold-to-repeat pulses.
module lc3_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic key_level,
  output logic key_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             pulse_q, pulse_d;
  logic             disagree;
  logic             rep_fire;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], key_n};
    disagree    = (sync_q[1] != level_q);
    cnt_d       = '0;
    accept_d    = 1'b0;
    // Accepting takes effect one cycle after the last stable sample is counted.
    if (!accept_q && disagree) begin
      if (cnt_q == CNT_LAST) accept_d = 1'b1;
      else                   cnt_d    = cnt_q + 1'b1;
    end
    level_d     = accept_q ? ~level_q : level_q;
    level_dly_d = level_q;
    pulse_d     = (level_dly_q & ~level_q) | rep_fire;
  end

`ifdef LC3_PANEL_REPEAT_EN
  localparam int                REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Counting starts the cycle after the press pulse, so repeats land exactly
  // REPEAT_CYCLES apart from it.
  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (!level_q && !level_dly_q) begin
      if (rep_cnt_q == REP_LAST) rep_fire  = 1'b1;
      else                       rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rep_cnt_q <= '0;
    else          rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      accept_q    <= 1'b0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      pulse_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      accept_q    <= accept_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
    end
  end

  assign key_level = level_q;
  assign key_pulse = pulse_q;

endmodule

// File: rtl/lc3_panel_io.sv
// LC-3 board front panel: debounced keys with press pulses and a registered
// seven-segment bank. Optional auto-repeat is enabled by LC3_PANEL_REPEAT_EN.
module lc3_panel_io
  import lc3_panel_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_DIGITS      = 6,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_KEYS-1:0]     key_n,
  output logic [NUM_KEYS-1:0]     key_level,
  output logic [NUM_KEYS-1:0]     key_pulse,
  input  logic [4*NUM_DIGITS-1:0] disp_value,
  input  logic                    disp_load,
  input  logic [NUM_DIGITS-1:0]   disp_blank,
  output logic [7*NUM_DIGITS-1:0] hex
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    lc3_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_n     (key_n[k]),
      .key_level (key_level[k]),
      .key_pulse (key_pulse[k])
    );
  end

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  // Blanking is read live every cycle; only the digit values need a load.
  always_comb begin
    shadow_d = disp_load ? disp_value : shadow_q;
    hex_d    = {NUM_DIGITS{SEG_BLANK}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!disp_blank[i]) hex_d[7*i +: 7] = seg_decode(shadow_q[4*i +: 4]);
    end
  end

  // NOTE: the shadow register is reset (not left uninitialised) so the panel
  // shows a defined value of all zeros as soon as reset releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      hex_q    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
    end
  end

  assign hex = hex_q;

endmodule
